// File: rtl/morse_tx_sched_pkg.sv
// Shared types, widths and helpers for the Morse transmit scheduler.
// Imported by the request interface, the unit timer and the top.
package morse_pkg;

  localparam int CODE_W  = 4;
  localparam int LEN_W   = 3;
  localparam int MAX_LEN = 4;
  localparam int UNIT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MARK,
    ST_GAP,
    ST_CHAR_GAP
  } state_e;

  // Lengths above MAX_LEN would shift past the end of the code word.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    return (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
  endfunction

endpackage

// File: rtl/morse_tx_sched_if.sv
// Two-requester character submission bus (code/length over valid/ready).
// The master modport is the requester side, slave is the scheduler side.
interface morse_tx_sched_if;
  import morse_pkg::*;

  logic              req0Valid_i;
  logic [CODE_W-1:0] req0Code_i;
  logic [LEN_W-1:0]  req0Length_i;
  logic              req0Ready_o;
  logic              req1Valid_i;
  logic [CODE_W-1:0] req1Code_i;
  logic [LEN_W-1:0]  req1Length_i;
  logic              req1Ready_o;

  modport master (
    output req0Valid_i, req0Code_i, req0Length_i,
    output req1Valid_i, req1Code_i, req1Length_i,
    input  req0Ready_o, req1Ready_o
  );

  modport slave (
    input  req0Valid_i, req0Code_i, req0Length_i,
    input  req1Valid_i, req1Code_i, req1Length_i,
    output req0Ready_o, req1Ready_o
  );

endinterface

// File: rtl/morse_unit_timer.sv
// Prescaler plus unit counter: after a load, o_expire is high on the last
// cycle of i_units * TICK_DIV cycles. Holding i_load keeps the prescaler at 0.
module morse_unit_timer
  import morse_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_load,
  input  logic [UNIT_W-1:0] i_units,
  output logic              o_expire
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0]  r_pre;
  logic [UNIT_W-1:0] r_units;
  logic              w_tick;

  assign w_tick   = (r_pre == PRE_LAST);
  assign o_expire = w_tick && (r_units == UNIT_W'(1));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pre   <= '0;
      r_units <= '0;
    end else if (i_load) begin
      r_pre   <= '0;
      r_units <= i_units;
    end else if (w_tick) begin
      r_pre   <= '0;
      r_units <= (r_units != '0) ? r_units - UNIT_W'(1) : r_units;
    end else begin
      r_pre   <= r_pre + PRE_W'(1);
    end
  end

endmodule

// File: rtl/morse_tx_sched.sv
// Round-robin arbiter over two character requesters feeding a single-clock
// dot/dash sequencer with unit-accurate mark, gap and character-gap timing.
module morse_tx_sched
  import morse_pkg::*;
#(
  parameter int unsigned TICK_DIV       = 1000,
  parameter int unsigned DASH_UNITS     = 3,
  parameter int unsigned GAP_UNITS      = 1,
  parameter int unsigned CHAR_GAP_UNITS = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  morse_tx_sched_if.slave        req_if,
  input  logic                   abort_i,
  output logic                   dotLed_o,
  output logic                   dashLed_o,
  output logic                   doneLed_o,
  output logic                   busy_o,
  output logic                   grantId_o
);

  state_e            r_state, w_next;
  logic [CODE_W-1:0] r_code, w_sel_code;
  logic [LEN_W-1:0]  r_len, w_sel_len;
  logic              r_grant, r_last, r_done;
  logic              w_grant, w_ready0, w_ready1, w_transfer;
  logic              w_load, w_expire, w_done;
  logic [UNIT_W-1:0] w_units;

  // A lone valid wins outright; otherwise favour whoever was not served last.
  always_comb begin
    w_grant = ~r_last;
    if (req_if.req0Valid_i && !req_if.req1Valid_i)      w_grant = 1'b0;
    else if (!req_if.req0Valid_i && req_if.req1Valid_i) w_grant = 1'b1;
  end

  assign w_ready0   = (r_state == ST_IDLE) && !w_grant && !abort_i;
  assign w_ready1   = (r_state == ST_IDLE) &&  w_grant && !abort_i;
  assign w_transfer = (w_ready0 && req_if.req0Valid_i) || (w_ready1 && req_if.req1Valid_i);
  assign w_sel_code = w_grant ? req_if.req1Code_i : req_if.req0Code_i;
  assign w_sel_len  = clamp_len(w_grant ? req_if.req1Length_i : req_if.req0Length_i);

  assign req_if.req0Ready_o = w_ready0;
  assign req_if.req1Ready_o = w_ready1;

  // The timer is reloaded on every state change and held while idle.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_units = '0;
    w_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_load = 1'b1;
        if (w_transfer) begin
          if (w_sel_len == '0) begin
            w_done = 1'b1;
          end else begin
            w_next  = ST_MARK;
            w_units = w_sel_code[0] ? UNIT_W'(DASH_UNITS) : UNIT_W'(1);
          end
        end
      end
      ST_MARK: begin
        if (w_expire) begin
          w_load = 1'b1;
          if (r_len > LEN_W'(1)) begin
            w_next  = ST_GAP;
            w_units = UNIT_W'(GAP_UNITS);
          end else begin
            w_next  = ST_CHAR_GAP;
            w_units = UNIT_W'(CHAR_GAP_UNITS);
          end
        end
      end
      ST_GAP: begin
        if (w_expire) begin
          w_load  = 1'b1;
          w_next  = ST_MARK;
          w_units = r_code[0] ? UNIT_W'(DASH_UNITS) : UNIT_W'(1);
        end
      end
      ST_CHAR_GAP: begin
        if (w_expire) begin
          w_load = 1'b1;
          w_next = ST_IDLE;
          w_done = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
    // Abort wins over any expiry, including the one that would signal done.
    if (abort_i && r_state != ST_IDLE) begin
      w_next = ST_IDLE;
      w_load = 1'b1;
      w_done = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_code  <= '0;
      r_len   <= '0;
      r_grant <= 1'b0;
      r_last  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_done;
      if (w_transfer) begin
        r_code  <= w_sel_code;
        r_len   <= w_sel_len;
        r_grant <= w_grant;
        r_last  <= w_grant;
      end else if (r_state == ST_MARK && w_expire && !abort_i) begin
        r_code <= r_code >> 1;
        r_len  <= r_len - LEN_W'(1);
      end
    end
  end

  morse_unit_timer #(.TICK_DIV(TICK_DIV)) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .i_load   (w_load),
    .i_units  (w_units),
    .o_expire (w_expire)
  );

  assign dotLed_o  = (r_state == ST_MARK) && !r_code[0];
  assign dashLed_o = (r_state == ST_MARK) &&  r_code[0];
  assign busy_o    = (r_state != ST_IDLE);
  assign doneLed_o = r_done;
  assign grantId_o = r_grant;

endmodule

// File: tb/tb_morse_tx_sched.sv
// Directed bench for morse_tx_sched at TICK_DIV=4: each character's LED,
// busy and done waveforms are captured per cycle and compared to hand-made masks.
module tb_morse_tx_sched;
  import morse_pkg::*;

  logic clk_i   = 1'b0;
  logic rst_i   = 1'b1;
  logic abort_i = 1'b0;
  logic dotLed_o, dashLed_o, doneLed_o, busy_o, grantId_o;

  int total = 0;
  int bad   = 0;

  // Bit c holds the output in cycle c after the transfer cycle (cycle 0).
  logic [127:0] v_dot, v_dash, v_busy, v_done;

  morse_tx_sched_if bus ();

  morse_tx_sched #(
    .TICK_DIV(4), .DASH_UNITS(3), .GAP_UNITS(1), .CHAR_GAP_UNITS(3)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_if    (bus),
    .abort_i   (abort_i),
    .dotLed_o  (dotLed_o),
    .dashLed_o (dashLed_o),
    .doneLed_o (doneLed_o),
    .busy_o    (busy_o),
    .grantId_o (grantId_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  function automatic logic [127:0] span(input int lo, input int hi);
    logic [127:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Presents one request at a negedge, samples its ready, then withdraws it.
  task automatic start_xfer(input bit which, input logic [3:0] code,
                            input logic [2:0] len, output logic rdy);
    @(negedge clk_i);
    if (!which) begin
      bus.req0Valid_i = 1'b1; bus.req0Code_i = code; bus.req0Length_i = len;
    end else begin
      bus.req1Valid_i = 1'b1; bus.req1Code_i = code; bus.req1Length_i = len;
    end
    #1 rdy = which ? bus.req1Ready_o : bus.req0Ready_o;
    @(posedge clk_i);
    #1;
    bus.req0Valid_i = 1'b0;
    bus.req1Valid_i = 1'b0;
  endtask

  task automatic observe(input int n);
    v_dot = '0; v_dash = '0; v_busy = '0; v_done = '0;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk_i);
      v_dot[c] = dotLed_o; v_dash[c] = dashLed_o;
      v_busy[c] = busy_o;  v_done[c] = doneLed_o;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    total++;
    if ({dotLed_o, dashLed_o, doneLed_o, busy_o, grantId_o} !== 5'b0) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=00000",
               {dotLed_o, dashLed_o, doneLed_o, busy_o, grantId_o});
    end
    @(posedge clk_i);
    #1 rst_i = 1'b0;
  endtask

  task automatic test_e;
    logic rdy;
    start_xfer(1'b0, 4'b0000, 3'd1, rdy);
    observe(18);
    total++; if (rdy !== 1'b1) begin bad++; $display("FAIL e_ready got=%b want=1", rdy); end
    total++; if (v_dot !== span(1, 4)) begin bad++; $display("FAIL e_dot got=%h want=%h", v_dot, span(1, 4)); end
    total++; if (v_dash !== '0) begin bad++; $display("FAIL e_dash got=%h want=0", v_dash); end
    total++; if (v_busy !== span(1, 16)) begin bad++; $display("FAIL e_busy got=%h want=%h", v_busy, span(1, 16)); end
    total++; if (v_done !== span(17, 17)) begin bad++; $display("FAIL e_done got=%h want=%h", v_done, span(17, 17)); end
  endtask

  task automatic test_a;
    logic rdy;
    start_xfer(1'b1, 4'b0010, 3'd2, rdy);
    observe(34);
    total++; if (rdy !== 1'b1) begin bad++; $display("FAIL a_ready got=%b want=1", rdy); end
    total++; if (v_dot !== span(1, 4)) begin bad++; $display("FAIL a_dot got=%h want=%h", v_dot, span(1, 4)); end
    total++; if (v_dash !== span(9, 20)) begin bad++; $display("FAIL a_dash got=%h want=%h", v_dash, span(9, 20)); end
    total++; if (v_busy !== span(1, 32)) begin bad++; $display("FAIL a_busy got=%h want=%h", v_busy, span(1, 32)); end
    total++; if (v_done !== span(33, 33)) begin bad++; $display("FAIL a_done got=%h want=%h", v_done, span(33, 33)); end
    total++; if ((v_dot & v_dash) !== '0) begin bad++; $display("FAIL a_overlap got=%h want=0", v_dot & v_dash); end
  endtask

  task automatic test_alternate;
    logic exp_g;
    @(negedge clk_i);
    bus.req0Valid_i = 1'b1; bus.req0Code_i = 4'b0000; bus.req0Length_i = 3'd1;
    bus.req1Valid_i = 1'b1; bus.req1Code_i = 4'b0000; bus.req1Length_i = 3'd1;
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_g = k[0];
      total++;
      if ({bus.req1Ready_o, bus.req0Ready_o} !== {exp_g, ~exp_g}) begin
        bad++;
        $display("FAIL alt_ready[%0d] got=%b want=%b", k,
                 {bus.req1Ready_o, bus.req0Ready_o}, {exp_g, ~exp_g});
      end
      @(negedge clk_i);
      total++;
      if ({busy_o, grantId_o} !== {1'b1, exp_g}) begin
        bad++;
        $display("FAIL alt_grant[%0d] got=%b want=%b", k, {busy_o, grantId_o}, {1'b1, exp_g});
      end
      repeat (15) @(negedge clk_i);
      @(negedge clk_i);
      total++;
      if (doneLed_o !== 1'b1) begin bad++; $display("FAIL alt_done[%0d] got=%b want=1", k, doneLed_o); end
    end
    bus.req0Valid_i = 1'b0;
    bus.req1Valid_i = 1'b0;
  endtask

  task automatic test_len0;
    logic rdy;
    start_xfer(1'b0, 4'b0101, 3'd0, rdy);
    observe(3);
    total++; if (rdy !== 1'b1) begin bad++; $display("FAIL len0_ready got=%b want=1", rdy); end
    total++; if (v_done !== span(1, 1)) begin bad++; $display("FAIL len0_done got=%h want=%h", v_done, span(1, 1)); end
    total++; if (v_busy !== '0) begin bad++; $display("FAIL len0_busy got=%h want=0", v_busy); end
    total++; if ((v_dot | v_dash) !== '0) begin bad++; $display("FAIL len0_led got=%h want=0", v_dot | v_dash); end
  endtask

  task automatic test_clamp;
    logic rdy;
    logic [127:0] exp_dash;
    exp_dash = span(1, 12) | span(17, 28) | span(33, 44) | span(49, 60);
    start_xfer(1'b1, 4'b1111, 3'd6, rdy);
    observe(75);
    total++; if (rdy !== 1'b1) begin bad++; $display("FAIL clamp_ready got=%b want=1", rdy); end
    total++; if (v_dash !== exp_dash) begin bad++; $display("FAIL clamp_dash got=%h want=%h", v_dash, exp_dash); end
    total++; if (v_dot !== '0) begin bad++; $display("FAIL clamp_dot got=%h want=0", v_dot); end
    total++; if (v_busy !== span(1, 72)) begin bad++; $display("FAIL clamp_busy got=%h want=%h", v_busy, span(1, 72)); end
    total++; if (v_done !== span(73, 73)) begin bad++; $display("FAIL clamp_done got=%h want=%h", v_done, span(73, 73)); end
  endtask

  task automatic test_abort_idle;
    @(negedge clk_i);
    bus.req0Valid_i = 1'b1; bus.req0Code_i = 4'b0000; bus.req0Length_i = 3'd1;
    abort_i = 1'b1;
    #1;
    total++; if (bus.req0Ready_o !== 1'b0) begin bad++; $display("FAIL abort_idle_ready got=%b want=0", bus.req0Ready_o); end
    @(posedge clk_i);
    #1;
    abort_i = 1'b0;
    bus.req0Valid_i = 1'b0;
    @(negedge clk_i);
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL abort_idle_busy got=%b want=0", busy_o); end
  endtask

  task automatic test_abort;
    logic rdy;
    start_xfer(1'b0, 4'b0010, 3'd2, rdy);
    total++; if (rdy !== 1'b1) begin bad++; $display("FAIL abort_ready0 got=%b want=1", rdy); end
    v_dash = '0; v_busy = '0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk_i);
      v_dash[c] = dashLed_o; v_busy[c] = busy_o;
      if (c == 5) begin
        bus.req1Valid_i = 1'b1; bus.req1Code_i = 4'b0000; bus.req1Length_i = 3'd1;
      end
    end
    abort_i = 1'b1;
    total++; if (v_dash !== span(9, 10)) begin bad++; $display("FAIL abort_dash_pre got=%h want=%h", v_dash, span(9, 10)); end
    total++; if (v_busy !== span(1, 10)) begin bad++; $display("FAIL abort_busy_pre got=%h want=%h", v_busy, span(1, 10)); end
    @(posedge clk_i);
    #1 abort_i = 1'b0;
    @(negedge clk_i);
    total++;
    if ({dotLed_o, dashLed_o, busy_o, doneLed_o} !== 4'b0) begin
      bad++;
      $display("FAIL abort_outputs got=%b want=0000", {dotLed_o, dashLed_o, busy_o, doneLed_o});
    end
    total++; if (bus.req1Ready_o !== 1'b1) begin bad++; $display("FAIL abort_ready1 got=%b want=1", bus.req1Ready_o); end
    @(posedge clk_i);
    #1 bus.req1Valid_i = 1'b0;
    observe(18);
    total++; if (v_dot !== span(1, 4)) begin bad++; $display("FAIL abort_next_dot got=%h want=%h", v_dot, span(1, 4)); end
    total++; if (v_busy !== span(1, 16)) begin bad++; $display("FAIL abort_next_busy got=%h want=%h", v_busy, span(1, 16)); end
    total++; if (v_done !== span(17, 17)) begin bad++; $display("FAIL abort_next_done got=%h want=%h", v_done, span(17, 17)); end
    total++; if (grantId_o !== 1'b1) begin bad++; $display("FAIL abort_next_grant got=%b want=1", grantId_o); end
  endtask

  task automatic test_reset_mid;
    logic rdy;
    start_xfer(1'b0, 4'b0001, 3'd1, rdy);
    observe(5);
    total++; if (v_dash !== span(1, 5)) begin bad++; $display("FAIL rstmid_dash got=%h want=%h", v_dash, span(1, 5)); end
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    total++;
    if ({dotLed_o, dashLed_o, busy_o, doneLed_o} !== 4'b0) begin
      bad++;
      $display("FAIL rstmid_outputs got=%b want=0000", {dotLed_o, dashLed_o, busy_o, doneLed_o});
    end
    observe(20);
    total++; if ((v_done | v_busy) !== '0) begin bad++; $display("FAIL rstmid_quiet got=%h want=0", v_done | v_busy); end
    @(negedge clk_i);
    bus.req0Valid_i = 1'b1; bus.req1Valid_i = 1'b1;
    #1;
    total++;
    if ({bus.req1Ready_o, bus.req0Ready_o} !== 2'b01) begin
      bad++;
      $display("FAIL rstmid_favour got=%b want=01", {bus.req1Ready_o, bus.req0Ready_o});
    end
    bus.req0Valid_i = 1'b0; bus.req1Valid_i = 1'b0;
  endtask

  initial begin
    bus.req0Valid_i = 1'b0; bus.req0Code_i = '0; bus.req0Length_i = '0;
    bus.req1Valid_i = 1'b0; bus.req1Code_i = '0; bus.req1Length_i = '0;
    test_reset();
    test_e();
    test_a();
    test_alternate();
    test_len0();
    test_clamp();
    test_abort_idle();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
